// File: rtl/tx_stream_arbiter.sv
// Packet-level arbiter sharing the TCP TX FIFO between the event stream (SFIFO)
// and the monitor packet stream (MFIFO); whole packets only, round-robin on ties.
module tx_stream_arbiter #(
  parameter int unsigned MON_BYTES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [12:0] DRS_READDEPTH,
  output logic        SFIFO_RDEN,
  input  logic        SFIFO_EMPTY,
  input  logic        SFIFO_VALID,
  input  logic [7:0]  SFIFO_DOUT,
  input  logic        MON_READY,
  output logic        MFIFO_RDEN,
  input  logic        MFIFO_EMPTY,
  input  logic        MFIFO_VALID,
  input  logic [7:0]  MFIFO_DOUT,
  output logic [7:0]  TX_DATA,
  output logic        TX_WREN,
  input  logic        TX_AFULL,
  output logic        BUSY,
  output logic [31:0] EVT_CNT,
  output logic [15:0] MON_CNT
);

  localparam int unsigned LEN_W = 18;
  localparam logic [LEN_W-1:0] MON_LEN = LEN_W'(MON_BYTES);

  typedef enum logic [1:0] {IDLE, EVT, MON, DRAIN} state_t;

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             last_mon;
  logic [LEN_W-1:0] evt_len;
  logic             ev_req;
  logic             mon_req;

  // 32 B header + 8 channels x (2 flag + 2 stopcell + 4 B per cell); wraps at 18 bits
  assign evt_len = LEN_W'(64) + LEN_W'({DRS_READDEPTH, 5'b0_0000});
  assign ev_req  = ~SFIFO_EMPTY;
  assign mon_req = MON_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      remain     <= '0;
      last_mon   <= 1'b1;
      SFIFO_RDEN <= 1'b0;
      MFIFO_RDEN <= 1'b0;
      TX_DATA    <= '0;
      TX_WREN    <= 1'b0;
      BUSY       <= 1'b0;
      EVT_CNT    <= '0;
      MON_CNT    <= '0;
    end else begin
      // Datapath: forward whichever source returned data, two cycles after RDEN
      TX_WREN <= SFIFO_VALID | MFIFO_VALID;
      if (SFIFO_VALID) begin
        TX_DATA <= SFIFO_DOUT;
      end else if (MFIFO_VALID) begin
        TX_DATA <= MFIFO_DOUT;
      end

      SFIFO_RDEN <= 1'b0;
      MFIFO_RDEN <= 1'b0;

      case (state)
        IDLE: begin
          if (ENABLE) begin
            if (ev_req && (!mon_req || last_mon)) begin
              state    <= EVT;
              remain   <= evt_len;
              last_mon <= 1'b0;
              BUSY     <= 1'b1;
            end else if (mon_req) begin
              state    <= MON;
              remain   <= MON_LEN;
              last_mon <= 1'b1;
              BUSY     <= 1'b1;
            end
          end
        end
        EVT: begin
          if (remain == '0) begin
            state <= DRAIN;
          end else if (!SFIFO_EMPTY && !TX_AFULL) begin
            SFIFO_RDEN <= 1'b1;
            remain     <= remain - LEN_W'(1);
          end
        end
        MON: begin
          if (remain == '0) begin
            state <= DRAIN;
          end else if (!MFIFO_EMPTY && !TX_AFULL) begin
            MFIFO_RDEN <= 1'b1;
            remain     <= remain - LEN_W'(1);
          end
        end
        DRAIN: begin
          // Leave only once the final read has returned its data
          if (!SFIFO_RDEN && !MFIFO_RDEN) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            if (last_mon) begin
              MON_CNT <= MON_CNT + 16'd1;
            end else begin
              EVT_CNT <= EVT_CNT + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Self-checking bench for tx_stream_arbiter: FIFO models, TX capture and a
// packet-level reference model of round-robin packet ordering.
module tb_tx_stream_arbiter;

  localparam int MON_B = 64;
  localparam int MEM_N = 4096;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic [12:0] DRS_READDEPTH;
  logic        SFIFO_RDEN, SFIFO_EMPTY, SFIFO_VALID;
  logic [7:0]  SFIFO_DOUT;
  logic        MON_READY;
  logic        MFIFO_RDEN, MFIFO_EMPTY, MFIFO_VALID;
  logic [7:0]  MFIFO_DOUT;
  logic [7:0]  TX_DATA;
  logic        TX_WREN;
  logic        TX_AFULL;
  logic        BUSY;
  logic [31:0] EVT_CNT;
  logic [15:0] MON_CNT;

  int tot = 0;
  int bad = 0;

  tx_stream_arbiter #(.MON_BYTES(MON_B)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .DRS_READDEPTH(DRS_READDEPTH),
    .SFIFO_RDEN(SFIFO_RDEN), .SFIFO_EMPTY(SFIFO_EMPTY), .SFIFO_VALID(SFIFO_VALID),
    .SFIFO_DOUT(SFIFO_DOUT), .MON_READY(MON_READY), .MFIFO_RDEN(MFIFO_RDEN),
    .MFIFO_EMPTY(MFIFO_EMPTY), .MFIFO_VALID(MFIFO_VALID), .MFIFO_DOUT(MFIFO_DOUT),
    .TX_DATA(TX_DATA), .TX_WREN(TX_WREN), .TX_AFULL(TX_AFULL), .BUSY(BUSY),
    .EVT_CNT(EVT_CNT), .MON_CNT(MON_CNT)
  );

  always #5 CLK = ~CLK;

  // Source FIFO models; empty looks past a read already issued this cycle
  logic [7:0] s_mem [MEM_N];
  logic [7:0] m_mem [MEM_N];
  int  s_lim = 0, m_lim = 0, s_rd, m_rd;
  int  s_ufl = 0, m_ufl = 0;
  bit  s_hold = 1'b0;

  assign SFIFO_EMPTY = s_hold || ((s_lim - s_rd) <= int'(SFIFO_RDEN));
  assign MFIFO_EMPTY = (m_lim - m_rd) <= int'(MFIFO_RDEN);
  assign MON_READY   = (m_lim - m_rd) >= MON_B;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_rd <= 0; m_rd <= 0;
      SFIFO_VALID <= 1'b0; MFIFO_VALID <= 1'b0;
      SFIFO_DOUT <= 8'h00; MFIFO_DOUT <= 8'h00;
    end else begin
      SFIFO_VALID <= SFIFO_RDEN;
      MFIFO_VALID <= MFIFO_RDEN;
      if (SFIFO_RDEN) begin
        SFIFO_DOUT <= s_mem[s_rd % MEM_N];
        s_rd <= s_rd + 1;
        if (s_rd >= s_lim) s_ufl <= s_ufl + 1;
      end
      if (MFIFO_RDEN) begin
        MFIFO_DOUT <= m_mem[m_rd % MEM_N];
        m_rd <= m_rd + 1;
        if (m_rd >= m_lim) m_ufl <= m_ufl + 1;
      end
    end
  end

  // TX capture and observation counters
  logic [7:0] obs [$];
  int cyc = 0, ovl = 0, m_rden_n = 0, last_s_cyc = 0, fall_cyc = 0;
  int wr_after = 0, max_after = 0;
  bit afull_q = 1'b0, busy_q = 1'b0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (TX_WREN) obs.push_back(TX_DATA);
    if (SFIFO_VALID && MFIFO_VALID) ovl = ovl + 1;
    if (SFIFO_RDEN) last_s_cyc = cyc;
    if (MFIFO_RDEN) m_rden_n = m_rden_n + 1;
    if (TX_AFULL && !afull_q) wr_after = 0;
    afull_q = TX_AFULL;
    if (TX_AFULL && TX_WREN) begin
      wr_after = wr_after + 1;
      if (wr_after > max_after) max_after = wr_after;
    end
    if (busy_q && !BUSY) fall_cyc = cyc;
    busy_q = BUSY;
  end

  // Reference model: packets leave whole, ties alternate, events win after reset
  logic [7:0] exp_q [$];

  function automatic int evt_len(input int d);
    return (64 + 32 * d) % 262144;
  endfunction

  function automatic void build_exp(input int n_ev, input int ev_len, input int n_mon);
    int ei = 0, mi = 0, so = 0, mo = 0;
    bit lm = 1'b1;
    exp_q.delete();
    while (ei < n_ev || mi < n_mon) begin
      if (ei < n_ev && (mi >= n_mon || lm)) begin
        for (int i = 0; i < ev_len; i++) exp_q.push_back(s_mem[(so + i) % MEM_N]);
        so += ev_len; ei++; lm = 1'b0;
      end else begin
        for (int i = 0; i < MON_B; i++) exp_q.push_back(m_mem[(mo + i) % MEM_N]);
        mo += MON_B; mi++; lm = 1'b1;
      end
    end
  endfunction

  function automatic int first_diff(input int st);
    for (int i = 0; i < exp_q.size(); i++)
      if (st + i >= obs.size() || obs[st + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic load_evt(input int n);
    for (int i = 0; i < n; i++) s_mem[(s_lim + i) % MEM_N] = 8'($urandom);
    s_lim = s_lim + n;
  endtask

  task automatic load_mon(input int pkts);
    for (int i = 0; i < pkts * MON_B; i++) m_mem[(m_lim + i) % MEM_N] = 8'($urandom);
    m_lim = m_lim + pkts * MON_B;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1; ENABLE = 1'b0; TX_AFULL = 1'b0; s_hold = 1'b0;
    s_lim = 0; m_lim = 0; DRS_READDEPTH = 13'd30;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic wait_bytes(input int st, input int n, input int budget);
    for (int c = 0; c < budget && (obs.size() - st) < n; c++) @(posedge CLK);
    repeat (6) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge CLK); #1 RST = 1'b1; #1;
    tot++;
    if ({SFIFO_RDEN, MFIFO_RDEN, TX_WREN, BUSY} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctl: got %b want 0000", {SFIFO_RDEN, MFIFO_RDEN, TX_WREN, BUSY});
    end
    tot++;
    if (TX_DATA !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", TX_DATA); end
    tot++;
    if (EVT_CNT !== 32'd0 || MON_CNT !== 16'd0) begin
      bad++; $display("FAIL reset_cnt: evt %0d mon %0d want 0 0", EVT_CNT, MON_CNT);
    end
    #1 RST = 1'b0;
    load_evt(96); load_mon(1);
    repeat (10) @(posedge CLK); #1;
    tot++;
    if (BUSY !== 1'b0 || obs.size() !== 0) begin
      bad++; $display("FAIL disabled_idle: busy %b bytes %0d want 0 0", BUSY, obs.size());
    end
  endtask

  task automatic test_single_event();
    int st, first, last, n, d;
    do_reset();
    load_evt(1024);
    st = obs.size(); first = -1; last = -1; n = 0;
    ENABLE = 1'b1;
    for (int c = 1; c <= 3000 && n < 1024; c++) begin
      @(posedge CLK); #1;
      if (c == 50) DRS_READDEPTH = 13'($urandom);
      if (TX_WREN) begin if (first < 0) first = c; last = c; n++; end
    end
    build_exp(1, 1024, 0);
    repeat (6) @(posedge CLK); #1;
    tot++;
    if (first !== 4) begin bad++; $display("FAIL grant_latency: first wren %0d want 4", first); end
    tot++;
    if (last - first !== 1023) begin bad++; $display("FAIL throughput: span %0d want 1023", last - first); end
    tot++;
    if (obs.size() - st !== 1024) begin bad++; $display("FAIL evt_len: got %0d want 1024", obs.size() - st); end
    d = first_diff(st);
    tot++;
    if (d !== -1) begin bad++; $display("FAIL evt_stream: first wrong byte %0d want none", d); end
    tot++;
    if (fall_cyc - last_s_cyc !== 2) begin
      bad++; $display("FAIL busy_fall: %0d cycles after last rden want 2", fall_cyc - last_s_cyc);
    end
    tot++;
    if (EVT_CNT !== 32'd1 || MON_CNT !== 16'd0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL evt_done: evt %0d mon %0d busy %b want 1 0 0", EVT_CNT, MON_CNT, BUSY);
    end
  endtask

  task automatic test_round_robin();
    int st, d;
    do_reset();
    DRS_READDEPTH = 13'd1;
    load_evt(2 * evt_len(1)); load_mon(2);
    st = obs.size();
    ENABLE = 1'b1;
    wait_bytes(st, 2 * 96 + 2 * MON_B, 3000);
    build_exp(2, 96, 2);
    d = first_diff(st);
    tot++;
    if (d !== -1) begin bad++; $display("FAIL rr_order: first wrong byte %0d want none", d); end
    tot++;
    if (obs.size() - st !== 320) begin bad++; $display("FAIL rr_len: got %0d want 320", obs.size() - st); end
    tot++;
    if (EVT_CNT !== 32'd2 || MON_CNT !== 16'd2) begin
      bad++; $display("FAIL rr_cnt: evt %0d mon %0d want 2 2", EVT_CNT, MON_CNT);
    end
  endtask

  task automatic test_afull();
    int st, d;
    do_reset();
    load_evt(1024);
    st = obs.size();
    ENABLE = 1'b1;
    for (int c = 0; c < 8000 && (obs.size() - st) < 1024; c++) begin
      @(posedge CLK); #1 TX_AFULL = 1'($urandom);
    end
    TX_AFULL = 1'b0;
    wait_bytes(st, 1024, 100);
    build_exp(1, 1024, 0);
    d = first_diff(st);
    tot++;
    if (d !== -1 || obs.size() - st !== 1024) begin
      bad++; $display("FAIL afull_stream: first wrong %0d len %0d want none 1024", d, obs.size() - st);
    end
    tot++;
    if (max_after > 3) begin bad++; $display("FAIL afull_slack: %0d writes after rise want <=3", max_after); end
  endtask

  task automatic test_stall();
    int st, d, m0, busy_low;
    do_reset();
    load_evt(1024); load_mon(1);
    st = obs.size();
    ENABLE = 1'b1;
    for (int c = 0; c < 2000 && (obs.size() - st) < 500; c++) @(posedge CLK);
    #1 s_hold = 1'b1;
    repeat (4) @(posedge CLK);
    m0 = m_rden_n; busy_low = 0;
    for (int c = 0; c < 200; c++) begin @(posedge CLK); #1; if (!BUSY) busy_low++; end
    tot++;
    if (m_rden_n - m0 !== 0 || busy_low !== 0) begin
      bad++; $display("FAIL stall_hold: mon reads %0d idle cycles %0d want 0 0", m_rden_n - m0, busy_low);
    end
    s_hold = 1'b0;
    wait_bytes(st, 1024 + MON_B, 3000);
    build_exp(1, 1024, 1);
    d = first_diff(st);
    tot++;
    if (d !== -1 || obs.size() - st !== 1024 + MON_B) begin
      bad++; $display("FAIL stall_stream: first wrong %0d len %0d want none 1088", d, obs.size() - st);
    end
    tot++;
    if (EVT_CNT !== 32'd1 || MON_CNT !== 16'd1) begin
      bad++; $display("FAIL stall_cnt: evt %0d mon %0d want 1 1", EVT_CNT, MON_CNT);
    end
  endtask

  task automatic test_enable_drop();
    int st, d, m0;
    do_reset();
    load_evt(1024); load_mon(1);
    st = obs.size();
    ENABLE = 1'b1;
    for (int c = 0; c < 200 && (obs.size() - st) < 10; c++) @(posedge CLK);
    #1 ENABLE = 1'b0;
    m0 = m_rden_n;
    wait_bytes(st, 1024, 3000);
    repeat (40) @(posedge CLK); #1;
    build_exp(1, 1024, 0);
    d = first_diff(st);
    tot++;
    if (d !== -1 || obs.size() - st !== 1024) begin
      bad++; $display("FAIL en_drop_stream: first wrong %0d len %0d want none 1024", d, obs.size() - st);
    end
    tot++;
    if (m_rden_n - m0 !== 0 || BUSY !== 1'b0 || EVT_CNT !== 32'd1) begin
      bad++; $display("FAIL en_drop_idle: mon reads %0d busy %b evt %0d want 0 0 1", m_rden_n - m0, BUSY, EVT_CNT);
    end
    ENABLE = 1'b1;
    wait_bytes(st, 1024 + MON_B, 500);
    tot++;
    if (MON_CNT !== 16'd1) begin bad++; $display("FAIL en_resume: mon %0d want 1", MON_CNT); end
  endtask

  task automatic test_rst_mid();
    int st, d;
    do_reset();
    load_evt(1024);
    st = obs.size();
    ENABLE = 1'b1;
    for (int c = 0; c < 2000 && (obs.size() - st) < 300; c++) @(posedge CLK);
    #1 RST = 1'b1; #1;
    tot++;
    if ({SFIFO_RDEN, MFIFO_RDEN, TX_WREN, BUSY} !== 4'b0000 || TX_DATA !== 8'h00 || EVT_CNT !== 32'd0) begin
      bad++; $display("FAIL rst_mid: ctl %b data %h evt %0d want 0000 00 0",
                      {SFIFO_RDEN, MFIFO_RDEN, TX_WREN, BUSY}, TX_DATA, EVT_CNT);
    end
    s_lim = 0; ENABLE = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;
    load_evt(1024);
    st = obs.size();
    ENABLE = 1'b1;
    wait_bytes(st, 1024, 3000);
    build_exp(1, 1024, 0);
    d = first_diff(st);
    tot++;
    if (d !== -1 || obs.size() - st !== 1024 || EVT_CNT !== 32'd1) begin
      bad++; $display("FAIL rst_fresh: first wrong %0d len %0d evt %0d want none 1024 1", d, obs.size() - st, EVT_CNT);
    end
  endtask

  task automatic test_len_wrap();
    int st, d;
    do_reset();
    DRS_READDEPTH = 13'h1FFF;
    load_evt(evt_len(8191));
    st = obs.size();
    ENABLE = 1'b1;
    wait_bytes(st, 32, 300);
    build_exp(1, evt_len(8191), 0);
    d = first_diff(st);
    tot++;
    if (d !== -1 || obs.size() - st !== 32 || EVT_CNT !== 32'd1) begin
      bad++; $display("FAIL len_wrap: first wrong %0d len %0d evt %0d want none 32 1", d, obs.size() - st, EVT_CNT);
    end
  endtask

  task automatic test_random();
    int st, d, dep, ne, nm, total;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      dep = $urandom_range(0, 8); ne = $urandom_range(1, 3); nm = $urandom_range(0, 3);
      DRS_READDEPTH = 13'(dep);
      load_evt(ne * evt_len(dep)); load_mon(nm);
      total = ne * evt_len(dep) + nm * MON_B;
      st = obs.size();
      ENABLE = 1'b1;
      for (int c = 0; c < 8000 && (obs.size() - st) < total; c++) begin
        @(posedge CLK); #1 TX_AFULL = ($urandom_range(0, 3) == 0);
      end
      TX_AFULL = 1'b0;
      wait_bytes(st, total, 100);
      build_exp(ne, evt_len(dep), nm);
      d = first_diff(st);
      tot++;
      if (d !== -1 || obs.size() - st !== total) begin
        bad++; $display("FAIL rand_stream it%0d: first wrong %0d len %0d want none %0d", it, d, obs.size() - st, total);
      end
      tot++;
      if (EVT_CNT !== 32'(ne) || MON_CNT !== 16'(nm) || BUSY !== 1'b0) begin
        bad++; $display("FAIL rand_cnt it%0d: evt %0d mon %0d busy %b want %0d %0d 0", it, EVT_CNT, MON_CNT, BUSY, ne, nm);
      end
    end
    tot++;
    if (ovl !== 0 || s_ufl + m_ufl !== 0) begin
      bad++; $display("FAIL valid_overlap_underflow: overlap %0d underflow %0d want 0 0", ovl, s_ufl + m_ufl);
    end
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b0; TX_AFULL = 1'b0; DRS_READDEPTH = 13'd30;
    test_reset();
    test_single_event();
    test_round_robin();
    test_afull();
    test_stall();
    test_enable_drop();
    test_rst_mid();
    test_len_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
